// File: rtl/fp_const_sub_pipe.sv
// fp_const_sub_pipe: three-stage pipelined OUT = K - B for IEEE-754-style
// operands, where K is a build-time constant (default 1.5). Rounding is by
// truncation and there are no guard or sticky bits. Denormals are treated
// as zero, special B values are resolved in stage 1, and a tag sideband
// travels through the pipeline in lockstep with the data.
//
// Flow control: there is no backpressure. When ce=1, every stage advances by
// one slot, and in_valid/B/in_tag are captured into stage 1. When ce=0, every
// stage, including all valids and tags, holds its value and in_valid is ignored.
// A slot whose valid bit is 0 still shifts through the pipeline, and it
// reaches the output with out_valid=0. OUT/out_tag are meaningful only while
// out_valid=1.
module fp_const_sub_pipe #(
    parameter int                   EXP_W  = 8,
    parameter int                   MAN_W  = 23,
    parameter logic [EXP_W+MAN_W:0] K_BITS = 32'h3FC00000,
    parameter int                   TAG_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   B,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    output logic [EXP_W+MAN_W:0]   OUT,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;

    localparam logic               K_SIGN = K_BITS[W-1];
    localparam logic [EXP_W-1:0]   K_EXP  = K_BITS[W-2:MAN_W];
    localparam logic [MAN_W-1:0]   K_MAN  = K_BITS[MAN_W-1:0];

    localparam logic [EXP_W-1:0]   EXP_ONES = '1;
    localparam logic [W-1:0]       QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Any alignment shift at or beyond this distance leaves nothing of S.
    localparam logic [31:0]        DMAX  = 32'(MAN_W + 2);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    // Leading-zero count of a hidden-bit-wide mantissa. All-zero returns MAN_W+1.
    function automatic logic [EW-1:0] lzc(input logic [MAN_W:0] v);
        logic [EW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = MAN_W; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + E_ONE;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: classify B, pick the larger magnitude, align, add/subtract
    // ------------------------------------------------------------------
    logic               b_sign;
    logic [EXP_W-1:0]   b_exp;
    logic [MAN_W-1:0]   b_man;

    assign b_sign = B[W-1];
    assign b_exp  = B[W-2:MAN_W];
    assign b_man  = B[MAN_W-1:0];

    logic               k_larger;
    logic               eff_sub;
    logic [EXP_W-1:0]   exp_a;
    logic [EXP_W-1:0]   exp_s;
    logic [EXP_W-1:0]   d;
    logic [MAN_W:0]     man_a;
    logic [MAN_W:0]     man_s;
    logic [MAN_W:0]     man_s_sh;
    logic [MAN_W+1:0]   raw_c;
    logic               sign_c;
    logic               spec_c;
    logic [W-1:0]       spec_val_c;

    // Magnitude compare, alignment by truncating shift, then the effective add/sub.
    always_comb begin
        k_larger   = ({K_EXP, K_MAN} >= {b_exp, b_man});
        // K - B: equal signs subtract magnitudes, opposite signs add them.
        eff_sub    = (K_SIGN == b_sign);
        exp_a      = K_EXP;
        man_a      = {1'b1, K_MAN};
        exp_s      = b_exp;
        man_s      = {1'b1, b_man};
        sign_c     = K_SIGN;
        man_s_sh   = '0;
        raw_c      = '0;
        spec_c     = 1'b0;
        spec_val_c = '0;

        if (!k_larger) begin
            exp_a  = b_exp;
            man_a  = {1'b1, b_man};
            exp_s  = K_EXP;
            man_s  = {1'b1, K_MAN};
            // B dominates, so the result carries the sign of -B.
            sign_c = ~b_sign;
        end

        d = exp_a - exp_s;
        if (32'(d) >= DMAX) man_s_sh = '0;
        else                man_s_sh = man_s >> d;

        if (eff_sub) raw_c = {1'b0, man_a} - {1'b0, man_s_sh};
        else         raw_c = {1'b0, man_a} + {1'b0, man_s_sh};

        // Special B values override the arithmetic result.
        if (b_exp == '0) begin
            spec_c     = 1'b1;
            spec_val_c = K_BITS;
        end else if (b_exp == EXP_ONES) begin
            spec_c = 1'b1;
            if (b_man != '0) spec_val_c = QNAN;
            else             spec_val_c = {~b_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic                   s1_valid;
    logic [TAG_W-1:0]       s1_tag;
    logic [MAN_W+1:0]       s1_raw;
    logic signed [EW-1:0]   s1_exp;
    logic                   s1_sign;
    logic                   s1_sub;
    logic                   s1_spec;
    logic [W-1:0]           s1_spec_val;

    // Stage 1 register: captures the aligned sum/difference and special flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_tag      <= '0;
            s1_raw      <= '0;
            s1_exp      <= '0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_spec     <= 1'b0;
            s1_spec_val <= '0;
        end else if (ce) begin
            s1_valid    <= in_valid;
            s1_tag      <= in_tag;
            s1_raw      <= raw_c;
            s1_exp      <= {2'b00, exp_a};
            s1_sign     <= sign_c;
            s1_sub      <= eff_sub;
            s1_spec     <= spec_c;
            s1_spec_val <= spec_val_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: carry renormalise or leading-one normalise
    // ------------------------------------------------------------------
    logic                   carry;
    logic [EW-1:0]          lz;
    logic [MAN_W-1:0]       norm_frac;
    logic signed [EW-1:0]   norm_exp;
    logic                   zero_c;

    // Pick the renormalisation shift and adjust the exponent to match.
    always_comb begin
        carry     = ~s1_sub & s1_raw[MAN_W+1];
        lz        = lzc(s1_raw[MAN_W:0]);
        norm_frac = '0;
        norm_exp  = s1_exp;
        // Exact cancellation is the only way to reach an all-zero magnitude.
        zero_c    = (s1_raw == '0);
        if (carry) begin
            norm_frac = s1_raw[MAN_W:1];
            norm_exp  = s1_exp + E_ONE;
        end else begin
            norm_frac = MAN_W'(s1_raw[MAN_W:0] << lz);
            norm_exp  = s1_exp - lz;
        end
    end

    logic                   s2_valid;
    logic [TAG_W-1:0]       s2_tag;
    logic [MAN_W-1:0]       s2_frac;
    logic signed [EW-1:0]   s2_exp;
    logic                   s2_sign;
    logic                   s2_zero;
    logic                   s2_spec;
    logic [W-1:0]           s2_spec_val;

    // Stage 2 register: holds the normalised fraction and the widened exponent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_tag      <= '0;
            s2_frac     <= '0;
            s2_exp      <= '0;
            s2_sign     <= 1'b0;
            s2_zero     <= 1'b0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
        end else if (ce) begin
            s2_valid    <= s1_valid;
            s2_tag      <= s1_tag;
            s2_frac     <= norm_frac;
            s2_exp      <= norm_exp;
            s2_sign     <= s1_sign;
            s2_zero     <= zero_c;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: range check and pack (truncation is already done)
    // ------------------------------------------------------------------
    logic [W-1:0] pack_c;

    // Handle specials, cancellation, underflow flush and overflow to infinity.
    always_comb begin
        pack_c = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        if (s2_spec) begin
            pack_c = s2_spec_val;
        end else if (s2_zero) begin
            pack_c = '0;
        end else if (s2_exp <= 0) begin
            pack_c = {s2_sign, {(W-1){1'b0}}};
        end else if (s2_exp >= E_MAX) begin
            pack_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // Output register: the result, its valid bit and its tag leave together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            OUT       <= '0;
            out_tag   <= '0;
        end else if (ce) begin
            out_valid <= s2_valid;
            OUT       <= pack_c;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_const_sub_pipe.sv
// Directed bench for fp_const_sub_pipe with default parameters (K = 1.5).
`timescale 1ns/1ps
module tb_fp_const_sub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] B = '0;
  logic [31:0] in_tag = '0;
  logic        out_valid;
  logic [31:0] OUT;
  logic [31:0] out_tag;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] tag_q[$];
  logic        ce_seen = 1'b0;

  // Hand-computed vectors: K - B with K = 1.5
  logic [31:0] vec_b [0:10] = '{
    32'h3FC00000, 32'h40000000, 32'hBF000000, 32'h3FBFFFFF, 32'h00000001,
    32'h7F800000, 32'h7FC00001, 32'h80000000, 32'hFF800000, 32'h3FE00000,
    32'hC0000000};
  logic [31:0] vec_e [0:10] = '{
    32'h00000000, 32'hBF000000, 32'h40000000, 32'h34000000, 32'h3FC00000,
    32'hFF800000, 32'h7FC00000, 32'h3FC00000, 32'h7F800000, 32'hBE800000,
    32'h40600000};

  // clock / reset block
  always #5 clk = ~clk;

  fp_const_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .B         (B),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .OUT       (OUT),
    .out_tag   (out_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Exact value of K - B in units of 2^-23, packed with truncation.
  // Valid for B exponents 127 and 128, where alignment loses no bits.
  function automatic logic [31:0] model_sub(input logic [31:0] b);
    longint          kv, bv, r;
    longint unsigned mag, mant;
    logic            sgn;
    int              p;
    kv = 64'd12582912;
    bv = longint'({40'd0, 1'b1, b[22:0]});
    if (b[30:23] == 8'd128) bv = bv * 2;
    if (b[31]) bv = -bv;
    r = kv - bv;
    if (r == 0) return 32'd0;
    sgn = (r < 0);
    mag = sgn ? -r : r;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p >= 23) mant = mag >> (p - 23);
    else         mant = mag << (23 - p);
    return {sgn, 8'(127 + p - 23), mant[22:0]};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] b, input logic [31:0] t, input logic [31:0] expv);
    in_valid = 1'b1;
    B = b;
    in_tag = t;
    exp_q.push_back(expv);
    tag_q.push_back(t);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    ce = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
    tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: a new output slot appears after each posedge taken with ce=1
  always @(posedge clk) ce_seen = ce;

  always @(negedge clk) begin
    if (!rst && ce_seen && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check("out_data", OUT, exp_q.pop_front());
        check("out_tag", out_tag, tag_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev_out, prev_tag, rb;
    logic        prev_v;
    int          sent, c;

    // reset state
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", OUT, 32'd0);
    check("reset_out_tag", out_tag, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    ce = 1'b1;
    tick();

    // 1: B=0.5, latency of exactly 3 ce-cycles
    send(32'h3F000000, 32'hA5A50101, 32'h3F800000);
    check("t1_lat1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_lat2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_lat3_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out", OUT, 32'h3F800000);
    check("t1_tag", out_tag, 32'hA5A50101);
    drain("t1_drain");

    // 2-4: directed vectors back to back
    for (int i = 0; i < 11; i++) send(vec_b[i], 32'h100 + 32'(i), vec_e[i]);
    drain("t234_drain");

    // 5: 8 inputs with ce toggled every 2 cycles; junk is offered while ce=0
    sent = 0;
    c = 0;
    while (sent < 8 && c < 100) begin
      ce = ((c / 2) % 2 == 0);
      in_valid = 1'b1;
      if (ce) begin
        B = vec_b[sent];
        in_tag = 32'h200 + 32'(sent);
        exp_q.push_back(vec_e[sent]);
        tag_q.push_back(32'h200 + 32'(sent));
      end else begin
        B = 32'h7FC00001;
        in_tag = 32'hDEAD0000 + 32'(c);
      end
      prev_out = OUT;
      prev_v = out_valid;
      prev_tag = out_tag;
      tick();
      if (ce) begin
        sent++;
      end else begin
        check("t5_hold_out", OUT, prev_out);
        check("t5_hold_valid", {31'd0, out_valid}, {31'd0, prev_v});
        check("t5_hold_tag", out_tag, prev_tag);
      end
      c++;
    end
    in_valid = 1'b0;
    drain("t5_drain");

    // 6: reset with three slots in flight
    send(32'h3F000000, 32'h301, 32'h3F800000);
    send(32'h3FC00000, 32'h302, 32'h00000000);
    send(32'h40000000, 32'h303, 32'hBF000000);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_out", OUT, 32'd0);
    check("t6_rst_tag", out_tag, 32'd0);
    exp_q.delete();
    tag_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end
    send(32'hBF000000, 32'h304, 32'h40000000);
    drain("t6_drain");

    // random B with exponent 127/128 against the exact-arith model
    for (int i = 0; i < 40; i++) begin
      rb = {1'($urandom_range(0, 1)), 8'(127 + $urandom_range(0, 1)),
            23'($urandom_range(0, 32'h7FFFFF))};
      send(rb, 32'h400 + 32'(i), model_sub(rb));
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
